// File: rtl/f_alu_pkg.sv
// Shared floating-ALU definitions: fclass bit indices, sticky flag indices,
// IEEE-754 single-precision constants and a one-hot class helper.
package f_alu_pkg;

  localparam int unsigned NCLS = 10;
  localparam int unsigned NFLG = 5;

  localparam logic [3:0] FCLS_NINF  = 4'd0;
  localparam logic [3:0] FCLS_NNORM = 4'd1;
  localparam logic [3:0] FCLS_NSUB  = 4'd2;
  localparam logic [3:0] FCLS_NZERO = 4'd3;
  localparam logic [3:0] FCLS_PZERO = 4'd4;
  localparam logic [3:0] FCLS_PSUB  = 4'd5;
  localparam logic [3:0] FCLS_PNORM = 4'd6;
  localparam logic [3:0] FCLS_PINF  = 4'd7;
  localparam logic [3:0] FCLS_SNAN  = 4'd8;
  localparam logic [3:0] FCLS_QNAN  = 4'd9;

  localparam int unsigned FLG_NAN  = 0;
  localparam int unsigned FLG_INF  = 1;
  localparam int unsigned FLG_SUBN = 2;
  localparam int unsigned FLG_ZERO = 3;
  localparam int unsigned FLG_SNAN = 4;

  localparam logic [7:0]  FP_EXP_MAX        = 8'hFF;
  localparam logic [31:0] DEFAULT_CANON_NAN = 32'h7FC0_0000;

  typedef logic [NCLS-1:0] fcls_t;
  typedef logic [NFLG-1:0] fflags_t;

  function automatic fcls_t cls_onehot(input logic [3:0] idx);
    fcls_t r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/f_classify.sv
// Combinational RISC-V fclass decoder for an IEEE-754 single value.
// Shared by several floating-ALU stages.
module f_classify
  import f_alu_pkg::*;
(
  input  logic [31:0] val,
  output fcls_t       cls
);

  logic        sign;
  logic [7:0]  expo;
  logic [22:0] frac;

  assign sign = val[31];
  assign expo = val[30:23];
  assign frac = val[22:0];

  // NOTE: every path below assigns cls, so no latch is inferred; the
  // up-front default keeps that true if a branch is added later.
  always_comb begin
    cls = '0;
    if (expo == FP_EXP_MAX) begin
      if (frac == '0)   cls = cls_onehot(sign ? FCLS_NINF : FCLS_PINF);
      else if (frac[22]) cls = cls_onehot(FCLS_QNAN);
      else               cls = cls_onehot(FCLS_SNAN);
    end else if (expo == '0) begin
      if (frac == '0) cls = cls_onehot(sign ? FCLS_NZERO : FCLS_PZERO);
      else            cls = cls_onehot(sign ? FCLS_NSUB : FCLS_PSUB);
    end else begin
      cls = cls_onehot(sign ? FCLS_NNORM : FCLS_PNORM);
    end
  end

endmodule

// File: rtl/f_result_post.sv
// Two-stage post-processing of F_MulSub results: classify, canonicalize NaNs,
// optional flush-to-zero (define F_FTZ_EN), sticky flags, valid/ready output.
module f_result_post
  import f_alu_pkg::*;
#(
  parameter logic [31:0] CANON_NAN = DEFAULT_CANON_NAN
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VLD,
  input  logic [31:0] IN_RES,
  output logic        IN_RDY,
  output logic        OUT_VLD,
  input  logic        OUT_RDY,
  output logic [31:0] OUT_RES,
  output logic [9:0]  OUT_CLASS,
  output logic [4:0]  FLAGS,
  input  logic        FLAGS_CLR
);

  fcls_t       in_cls;
  logic        s1_vld, s2_vld;
  logic [31:0] s1_res, s2_res;
  fcls_t       s1_cls, s2_cls;
  logic        s2_subn;
  logic        s1_adv, s2_adv;
  logic        out_xfer;
  logic        s1_subn;
  logic [31:0] s2_res_d;
  fcls_t       s2_cls_d;
  fflags_t     flags_q, new_bits;

  f_classify u_classify (
    .val (IN_RES),
    .cls (in_cls)
  );

  // A full pipeline still accepts when the output drains this same cycle.
  assign s2_adv   = !s2_vld || OUT_RDY;
  assign s1_adv   = !s1_vld || s2_adv;
  assign IN_RDY   = s1_adv;
  assign out_xfer = s2_vld && OUT_RDY;

  assign s1_subn = s1_cls[FCLS_NSUB] | s1_cls[FCLS_PSUB];

  always_comb begin
    s2_res_d = s1_res;
    s2_cls_d = s1_cls;
    if (s1_cls[FCLS_SNAN] || s1_cls[FCLS_QNAN]) begin
      s2_res_d = CANON_NAN;
    end
`ifdef F_FTZ_EN
    else if (s1_subn) begin
      s2_res_d = {s1_res[31], 31'b0};
      s2_cls_d = cls_onehot(s1_res[31] ? FCLS_NZERO : FCLS_PZERO);
    end
`endif
  end

  // ZERO follows the reported class, so a flushed subnormal also sets it.
  always_comb begin
    new_bits = '0;
    if (out_xfer) begin
      new_bits[FLG_NAN]  = s2_cls[FCLS_SNAN] | s2_cls[FCLS_QNAN];
      new_bits[FLG_SNAN] = s2_cls[FCLS_SNAN];
      new_bits[FLG_INF]  = s2_cls[FCLS_NINF] | s2_cls[FCLS_PINF];
      new_bits[FLG_ZERO] = s2_cls[FCLS_NZERO] | s2_cls[FCLS_PZERO];
      new_bits[FLG_SUBN] = s2_subn;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples pre-edge values; the data registers are reset too because the
  // output value itself must read zero after reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      s1_res  <= '0;
      s1_cls  <= '0;
      s2_res  <= '0;
      s2_cls  <= '0;
      s2_subn <= 1'b0;
      flags_q <= '0;
    end else begin
      if (s1_adv) begin
        s1_vld <= IN_VLD;
        if (IN_VLD) begin
          s1_res <= IN_RES;
          s1_cls <= in_cls;
        end
      end
      if (s2_adv) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2_res  <= s2_res_d;
          s2_cls  <= s2_cls_d;
          s2_subn <= s1_subn;
        end
      end
      // Clear first, then OR, so an event coinciding with a clear survives.
      if (FLAGS_CLR) flags_q <= new_bits;
      else           flags_q <= flags_q | new_bits;
    end
  end

  assign OUT_VLD   = s2_vld;
  assign OUT_RES   = s2_res;
  assign OUT_CLASS = s2_cls;
  assign FLAGS     = flags_q;

endmodule
